mmu_arbiter: RTL and testbench
==============================

Name: mmu_arbiter

Overview:
- Shares the single mmu port among NUM_REQ requesters, for example instruction fetch, data load/store and a debug/DMA port.
- Arbitration is round-robin with bounded burst hold.
- The block issues at most one mmu access per cycle and routes the mmu's one-cycle-latency read data back to the requester that issued the access.
- Sits between the core-side request ports and the mmu.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- MAX_BURST, 4, maximum consecutive accepted beats one requester may hold the grant while others are waiting (1..15).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid & ready.
- req_mode  input  NUM_REQ  1 = write, 0 = read.
- req_address  input  NUM_REQ x 32  packed request addresses.
- req_data  input  NUM_REQ x 32  packed write data.
- rsp_valid  output  NUM_REQ  one-hot response strobe.
- rsp_data  output  32  read data; meaningful only with rsp_valid for a read.
- mmu_address  output  32  to mmu address_in.
- mmu_mode  output  1  to mmu mode.
- mmu_data_in  output  32  to mmu data_in.
- mmu_data_out  input  32  from mmu data_out.

Behaviour:
- Reset (async, reset_n=0):
  - req_ready=0, rsp_valid=0, rsp_data=0.
  - Round-robin pointer = 0, burst counter = 0, state = IDLE.
  - Any in-flight response is discarded and never signalled.
- Arbitration is combinational each cycle. Priority is the pointer, then pointer+1, ... modulo NUM_REQ.
- req_ready is one-hot to the winner, or 0 when no req_valid is asserted.
- The mmu outputs are a combinational mux of the winner's mode/address/data.
- With no winner: mmu_mode=0 (read), mmu_address=0, mmu_data_in=0. Address 0 maps to no storage, so idle reads are harmless.
- FSM:
  - IDLE: no grant held. On a winner, accept the beat, latch the owner, burst counter=1, go to HOLD.
  - HOLD: the owner keeps priority while owner req_valid=1 and the counter < MAX_BURST.
  - HOLD, counter reaches MAX_BURST with another requester valid: the next cycle grants the next requester after the owner. The counter resets to 1 for the new owner.
  - HOLD, counter reaches MAX_BURST with no other requester valid: the owner continues and the counter saturates.
  - HOLD, owner drops req_valid: go to IDLE and set pointer = owner+1.
  - Any grant change: pointer = previous owner+1.
- Response pipeline: a registered tag (valid, owner index, mode) is captured for each accepted beat.
  - Cycle N+1 after acceptance: rsp_valid[owner]=1.
  - If read: rsp_data = mmu_data_out in that cycle.
  - If write: rsp_data holds its previous value, and rsp_valid serves as the write acknowledge.
- Throughput is one beat per cycle, back-to-back, including alternating requesters and a read immediately after a write to the same address. The write data is stored at N, and the read issued at N+1 returns the new value at N+2.
- Requesters must hold mode/address/data stable while valid and not ready.
- Reset deasserting mid-stream: first grant is no earlier than the first posedge after release.

Optional Feature:
- Macro MMU_ARB_STATS_EN.
- Defined:
  - Adds output grant_count (NUM_REQ x 16), per-requester accepted-beat counters.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clear; stats_clear=1 zeroes all counters synchronously and takes precedence over an increment in the same cycle.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mmu_arb_pkg:
  - MODE_READ/MODE_WRITE constants.
  - arb_state_t enum {IDLE, HOLD}.
  - rsp_tag_t struct {valid, owner index, mode}.
- One sub-module, rr_pick: combinational round-robin picker (valid vector + pointer -> one-hot grant + index).

Test Plan:
- Reset and idle:
  - Hold reset_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, mmu_mode=0.
  - After release, first grant goes to requester 0.
- Single-requester write/read:
  - Req0 writes 32'hDEADBEEF to 'h60.
  - Next cycle req0 reads 'h60 -> rsp_valid=2'b01 at N+1 (write ack).
  - rsp_valid=2'b01 with rsp_data=32'hDEADBEEF at N+2.
- Burst limit:
  - Both requesters continuously valid, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0...
  - rsp_valid follows the same sequence delayed one cycle.
- Early release:
  - Req0 valid for 2 beats then drops while req1 is valid -> req1 is granted the cycle after req0's last beat.
  - Pointer=1.
- Reset mid-operation:
  - Assert reset_n=0 in the cycle after a read is accepted -> no rsp_valid for that read.
  - Outputs return to reset values immediately (asynchronously).
- Stats (MMU_ARB_STATS_EN):
  - After the burst test's 8 beats -> grant_count = {4,4}.
  - stats_clear concurrent with a grant -> counter = 0.

Source files
------------

// File: rtl/mmu_arb_pkg.sv
// Purpose: shared types and helpers for the mmu port arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mmu_arb_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Requester index; wide enough for up to four requesters.
  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // One entry per accepted beat, consumed in the following cycle.
  typedef struct packed {
    logic valid;
    idx_t owner;
    logic mode;
  } rsp_tag_t;

  // Next requester after i, wrapping at n.
  function automatic idx_t next_idx(input idx_t i, input int n);
    if (int'(i) >= n - 1) return '0;
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/mmu_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker, priority starts at ptr_i and wraps.
// Latency: zero cycles (pure combinational).
// Backpressure: none; grant_o is all-zero when no valid_i bit is set.
module rr_pick
  import mmu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  idx_t               ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output idx_t               idx_o,
  output logic               any_o
);

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first valid requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_o && valid_i[j] && (j == ((int'(ptr_i) + k) % NUM_REQ))) begin
          any_o      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = idx_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Purpose: shares one mmu port among NUM_REQ requesters, round-robin with bounded burst hold
//          (optional per-requester beat counters when MMU_ARB_STATS_EN is defined).
// Latency: request accepted in the cycle valid&ready; response strobe/read data one cycle later.
// Backpressure: req_ready is one-hot to the winner; losers hold their request stable until granted.
module mmu_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_mode,
  input  logic [NUM_REQ*32-1:0] req_address,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [31:0]           mmu_address,
  output logic                  mmu_mode,
  output logic [31:0]           mmu_data_in,
  input  logic [31:0]           mmu_data_out
`ifdef MMU_ARB_STATS_EN
  ,
  input  logic                  stats_clear,
  output logic [NUM_REQ*16-1:0] grant_count
`endif
);

  arb_state_t state_q, state_d;
  idx_t       owner_q, owner_d;
  idx_t       ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  rsp_tag_t   tag_q, tag_d;
  logic [31:0] rsp_data_q;

  logic               owner_vld;
  logic               others_vld;
  logic               limit_hit;
  idx_t               eff_ptr;
  logic [NUM_REQ-1:0] pick_valid;
  logic [NUM_REQ-1:0] grant;
  idx_t               win_idx;
  logic               win_any;

  // Owner status and burst limit as seen this cycle.
  always_comb begin
    owner_vld  = 1'b0;
    others_vld = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (idx_t'(j) == owner_q) owner_vld = req_valid[j];
      else if (req_valid[j])    others_vld = 1'b1;
    end
    limit_hit = (cnt_q >= 4'(MAX_BURST));
  end

  // The owner keeps priority unless it dropped valid or used up its burst while others wait.
  always_comb begin
    if (state_q == HOLD) begin
      if (owner_vld && !(limit_hit && others_vld)) eff_ptr = owner_q;
      else                                         eff_ptr = next_idx(owner_q, NUM_REQ);
    end else begin
      eff_ptr = ptr_q;
    end
  end

  // No grants while reset is asserted, so nothing can be accepted before release.
  assign pick_valid = reset_n ? req_valid : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (eff_ptr),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign req_ready = grant;

  // Steer the winner onto the mmu port; idle cycles issue a harmless read of address 0.
  always_comb begin
    mmu_mode    = MODE_READ;
    mmu_address = '0;
    mmu_data_in = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        mmu_mode    = req_mode[j];
        mmu_address = req_address[j*32 +: 32];
        mmu_data_in = req_data[j*32 +: 32];
      end
    end
  end

  // Grant FSM: pointer, owner and burst counter bookkeeping.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (win_any) begin
      state_d = HOLD;
      owner_d = win_idx;
      if (state_q == HOLD && win_idx == owner_q) begin
        cnt_d = limit_hit ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
        if (state_q == HOLD) ptr_d = next_idx(owner_q, NUM_REQ);
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      if (state_q == HOLD) ptr_d = next_idx(owner_q, NUM_REQ);
    end
  end

  // Tag for the beat accepted this cycle; answered next cycle.
  always_comb begin
    tag_d.valid = win_any;
    tag_d.owner = win_idx;
    tag_d.mode  = mmu_mode;
  end

  // Response strobe to the beat's owner; read data passes straight through, writes hold it.
  always_comb begin
    rsp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      rsp_valid[j] = tag_q.valid && (tag_q.owner == idx_t'(j));
    end
    rsp_data = (tag_q.valid && tag_q.mode == MODE_READ) ? mmu_data_out : rsp_data_q;
  end

  // Arbiter and response state; reset drops any in-flight response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data;
    end
  end

`ifdef MMU_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_q;

  // Saturating accepted-beat counters; clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (stats_clear) begin
          stat_q[j*16 +: 16] <= '0;
        end else if (grant[j] && stat_q[j*16 +: 16] != 16'hFFFF) begin
          stat_q[j*16 +: 16] <= stat_q[j*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign grant_count = stat_q;
`endif

endmodule

// File: tb/tb_mmu_arbiter.sv
// Purpose: self-checking bench for mmu_arbiter with a one-cycle-latency mmu model.
// Latency: responses are expected exactly one cycle after each accepted beat.
// Backpressure: expected grant pattern comes from the stimulus table.
module tb_mmu_arbiter;

  localparam int NR = 2;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  req_mode;
  logic [NR*32-1:0] req_address;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]  rsp_valid;
  logic [31:0]    rsp_data;
  logic [31:0]    mmu_address;
  logic           mmu_mode;
  logic [31:0]    mmu_data_in;
  logic [31:0]    mmu_data_out = '0;
`ifdef MMU_ARB_STATS_EN
  logic           stats_clear = 1'b0;
  logic [NR*16-1:0] grant_count;
`endif

  mmu_arbiter #(.NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_address  (req_address),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .mmu_address  (mmu_address),
    .mmu_mode     (mmu_mode),
    .mmu_data_in  (mmu_data_in),
    .mmu_data_out (mmu_data_out)
`ifdef MMU_ARB_STATS_EN
    ,
    .stats_clear  (stats_clear),
    .grant_count  (grant_count)
`endif
  );

  always #5 clock = ~clock;

  // mmu model: writes land at the edge, reads return one cycle later; address 0 has no storage.
  logic [31:0] mmu_mem [logic [31:0]];
  always @(posedge clock) begin
    if (mmu_mode) begin
      if (mmu_address != 32'd0) mmu_mem[mmu_address] = mmu_data_in;
    end else begin
      mmu_data_out <= mmu_mem.exists(mmu_address) ? mmu_mem[mmu_address] : 32'd0;
    end
  end

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  m;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  rdy;
  } vec_t;

  typedef struct {
    logic [1:0]  oh;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd = 32'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] v, input logic [1:0] m,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [1:0] rdy);
    vec_t x;
    x.v = v; x.m = m; x.a0 = a0; x.d0 = d0; x.a1 = a1; x.d1 = d1; x.rdy = rdy;
    vecs.push_back(x);
  endfunction

  task automatic drive(input vec_t x);
    req_valid   = x.v;
    req_mode    = x.m;
    req_address = {x.a1, x.a0};
    req_data    = {x.d1, x.d0};
  endtask

  // Compare the response against the beat accepted in the previous cycle, if any.
  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(e.oh));
      if (e.rd) last_rd = e.data;
      chk({tag, "_rsp_data"}, rsp_data, last_rd);
    end else begin
      chk({tag, "_rsp_idle"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  // Check grant and mmu mux against the table, then queue the expected response.
  task automatic check_req(input vec_t x, input string tag);
    exp_t        e;
    logic [31:0] a, d;
    logic        m;
    chk({tag, "_ready"}, 32'(req_ready), 32'(x.rdy));
    a = 32'd0; d = 32'd0; m = 1'b0;
    if (x.rdy == 2'b01) begin a = x.a0; d = x.d0; m = x.m[0]; end
    if (x.rdy == 2'b10) begin a = x.a1; d = x.d1; m = x.m[1]; end
    chk({tag, "_mmu_mode"}, 32'(mmu_mode), 32'(m));
    chk({tag, "_mmu_addr"}, mmu_address, a);
    chk({tag, "_mmu_wdata"}, mmu_data_in, d);
    if (x.rdy != 2'b00) begin
      e.oh = x.rdy;
      e.rd = !m;
      e.data = 32'd0;
      if (m) begin
        if (a != 32'd0) ref_mem[a] = d;
      end else begin
        e.data = ref_mem.exists(a) ? ref_mem[a] : 32'd0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic cycle(input vec_t x, input string tag);
    drive(x);
    #3;
    check_rsp(tag);
    check_req(x, tag);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t x;
    // burst limit with interleaved write/read traffic
    add(2'b11, 2'b11, 32'h60, 32'hDEADBEEF, 32'h80, 32'h12345678, 2'b01); // c0
    add(2'b11, 2'b10, 32'h60, 32'h0,        32'h80, 32'h12345678, 2'b01); // c1 read-after-write
    add(2'b11, 2'b10, 32'h64, 32'h0,        32'h80, 32'h12345678, 2'b01); // c2
    add(2'b11, 2'b11, 32'h64, 32'h0BADF00D, 32'h80, 32'h12345678, 2'b01); // c3
    add(2'b11, 2'b10, 32'h64, 32'h0,        32'h80, 32'h12345678, 2'b10); // c4 switch
    add(2'b11, 2'b00, 32'h64, 32'h0,        32'h80, 32'h0,        2'b10); // c5
    add(2'b11, 2'b10, 32'h64, 32'h0,        32'h84, 32'hCAFEF00D, 2'b10); // c6
    add(2'b11, 2'b00, 32'h64, 32'h0,        32'h84, 32'h0,        2'b10); // c7
    add(2'b11, 2'b00, 32'h64, 32'h0,        32'h80, 32'h0,        2'b01); // c8 back to 0
    add(2'b11, 2'b00, 32'h60, 32'h0,        32'h80, 32'h0,        2'b01); // c9
    add(2'b10, 2'b00, 32'h0,  32'h0,        32'h80, 32'h0,        2'b10); // c10 early release
    add(2'b00, 2'b00, 32'h0,  32'h0,        32'h0,  32'h0,        2'b00); // c11
    add(2'b11, 2'b00, 32'h84, 32'h0,        32'h80, 32'h0,        2'b01); // c12
    add(2'b00, 2'b00, 32'h0,  32'h0,        32'h0,  32'h0,        2'b00); // c13 pointer -> 1
    add(2'b11, 2'b00, 32'h84, 32'h0,        32'h80, 32'h0,        2'b10); // c14
    add(2'b10, 2'b10, 32'h0,  32'h0,        32'h88, 32'h101,      2'b10); // c15
    add(2'b10, 2'b10, 32'h0,  32'h0,        32'h88, 32'h102,      2'b10); // c16
    add(2'b10, 2'b10, 32'h0,  32'h0,        32'h88, 32'h103,      2'b10); // c17 counter at limit
    add(2'b10, 2'b00, 32'h0,  32'h0,        32'h88, 32'h0,        2'b10); // c18 saturated
    add(2'b10, 2'b00, 32'h0,  32'h0,        32'h88, 32'h0,        2'b10); // c19
    add(2'b11, 2'b01, 32'h0,  32'hFFFFFFFF, 32'h88, 32'h0,        2'b01); // c20 write to addr 0
    add(2'b11, 2'b00, 32'h0,  32'h0,        32'h88, 32'h0,        2'b01); // c21 read addr 0
    add(2'b00, 2'b00, 32'h0,  32'h0,        32'h0,  32'h0,        2'b00); // c22

    // reset with requests pending
    req_valid = 2'b11; req_mode = 2'b11;
    req_address = {32'h80, 32'h60}; req_data = {32'h12345678, 32'hDEADBEEF};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_mmu_mode", 32'(mmu_mode), 32'd0);
    chk("rst_mmu_addr", mmu_address, 32'd0);
`ifdef MMU_ARB_STATS_EN
    chk("rst_stats", grant_count, 32'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i], $sformatf("v%0d", i));
`ifdef MMU_ARB_STATS_EN
      if (i == 7) chk("stats_after_burst", grant_count, {16'd4, 16'd4});
`endif
    end

    // stats_clear concurrent with a grant
    x.v = 2'b01; x.m = 2'b00; x.a0 = 32'h60; x.d0 = 32'h0; x.a1 = 32'h0; x.d1 = 32'h0; x.rdy = 2'b01;
`ifdef MMU_ARB_STATS_EN
    stats_clear = 1'b1;
`endif
    cycle(x, "clr");
`ifdef MMU_ARB_STATS_EN
    chk("stats_clear", grant_count, 32'd0);
    stats_clear = 1'b0;
`endif
    cycle(x, "post_clr");
`ifdef MMU_ARB_STATS_EN
    chk("stats_inc", grant_count, {16'd0, 16'd1});
`endif

    // reset in the cycle after a read is accepted: its response must vanish
    drive(x);
    #3;
    check_rsp("mid");
    check_req(x, "mid");
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_mmu_mode", 32'(mmu_mode), 32'd0);
    sb.delete();
    last_rd = 32'd0;
    @(posedge clock);
    #1;
    chk("midrst_hold_rsp", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    x.v = 2'b00; x.rdy = 2'b00;
    cycle(x, "after_rst");
    cycle(x, "after_rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
